mem_access_stage: RTL and testbench



---
 rtl/mem_access_stage.sv | 151 +++++++++++++++
 tb/tb_mem_access_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: aligned loads/stores over a req/ack data-memory port.
// Stalls upstream while an access is in flight and supplies the write-back value.
module mem_access_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic        reg_write_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        misalign_o,
  output logic [31:0] reg_write_data_o,
  output logic        reg_write_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_load_q;

  logic        w_memop;
  logic        w_mis;
  logic        w_issue;
  logic        w_we;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ldata;

  assign w_off   = alu_result_i[1:0];
  assign w_memop = valid_i & (mem_read_i | mem_write_i);
  // A load wins when both read and write are flagged.
  assign w_we    = mem_write_i & ~mem_read_i;

  always_comb begin
    w_mis = 1'b0;
    case (funct3_i[1:0])
      2'b01:   w_mis = w_off[0];
      2'b10:   w_mis = (w_off != 2'b00);
      default: w_mis = 1'b0;
    endcase
    w_mis = w_mis & w_memop;
  end

  assign w_issue    = (r_state == S_IDLE) & w_memop & ~w_mis;
  assign stall_o    = w_issue | (r_state == S_BUSY);
  assign misalign_o = (r_state == S_IDLE) & w_mis;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << w_off;
        w_wdata = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = dmem_rdata_i[7:0];
    case (w_off)
      2'b01:   w_byte = dmem_rdata_i[15:8];
      2'b10:   w_byte = dmem_rdata_i[23:16];
      2'b11:   w_byte = dmem_rdata_i[31:24];
      default: w_byte = dmem_rdata_i[7:0];
    endcase
    w_half  = w_off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    w_ldata = dmem_rdata_i;
    case (funct3_i)
      3'b000:  w_ldata = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ldata = {{16{w_half[15]}}, w_half};
      3'b100:  w_ldata = {24'd0, w_byte};
      3'b101:  w_ldata = {16'd0, w_half};
      default: w_ldata = dmem_rdata_i;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_next = S_BUSY;
      S_BUSY:  if (dmem_ack_i) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= 32'd0;
      r_be     <= 4'd0;
      r_wdata  <= 32'd0;
      r_load_q <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_req   <= 1'b1;
        r_we    <= w_we;
        r_addr  <= {alu_result_i[31:2], 2'b00};
        r_be    <= w_be;
        r_wdata <= w_wdata;
      end
      if ((r_state == S_BUSY) && dmem_ack_i) begin
        r_req <= 1'b0;
        if (!r_we) r_load_q <= w_ldata;
      end
    end
  end

  assign dmem_req_o   = r_req;
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = r_addr;
  assign dmem_be_o    = r_be;
  assign dmem_wdata_o = r_wdata;

  assign reg_write_o      = valid_i & reg_write_i & ~stall_o & ~misalign_o;
  assign reg_write_data_o = ((r_state == S_DONE) && !r_we) ? r_load_q
                                                           : alu_result_i;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a request scoreboard.
// Expected memory requests are queued when an instruction is driven.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [31:0] alu_result_i;
  logic [31:0] store_data_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [2:0]  funct3_i;
  logic        reg_write_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o;
  logic        misalign_o;
  logic [31:0] reg_write_data_o;
  logic        reg_write_o;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  req_t exp_q[$];
  int   n_cmp;
  int   n_bad;

  mem_access_stage dut (
    .clk              (clk),
    .rst              (rst),
    .valid_i          (valid_i),
    .alu_result_i     (alu_result_i),
    .store_data_i     (store_data_i),
    .mem_read_i       (mem_read_i),
    .mem_write_i      (mem_write_i),
    .funct3_i         (funct3_i),
    .reg_write_i      (reg_write_i),
    .dmem_req_o       (dmem_req_o),
    .dmem_we_o        (dmem_we_o),
    .dmem_addr_o      (dmem_addr_o),
    .dmem_be_o        (dmem_be_o),
    .dmem_wdata_o     (dmem_wdata_o),
    .dmem_ack_i       (dmem_ack_i),
    .dmem_rdata_i     (dmem_rdata_i),
    .stall_o          (stall_o),
    .misalign_o       (misalign_o),
    .reg_write_data_o (reg_write_data_o),
    .reg_write_o      (reg_write_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sd, input logic rw);
    valid_i      = 1'b1;
    mem_read_i   = rd;
    mem_write_i  = wr;
    funct3_i     = f3;
    alu_result_i = addr;
    store_data_i = sd;
    reg_write_i  = rw;
  endtask

  // Runs the current instruction to completion, serving the memory side.
  task automatic run(input string tag, input int nwait,
                     input logic [31:0] rdata, input int exp_stall,
                     input logic [31:0] exp_wb, input logic exp_rw,
                     input logic exp_mis);
    int   st;
    int   busy;
    bit   done;
    req_t e;
    st   = 0;
    busy = 0;
    done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!stall_o) begin
        done = 1;
        break;
      end
      st++;
      if (dmem_req_o) begin
        if (busy == 0) begin
          if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_req"}, 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk({tag, "_we"}, {31'd0, dmem_we_o}, {31'd0, e.we});
            chk({tag, "_addr"}, dmem_addr_o, e.addr);
            if (e.we) begin
              chk({tag, "_be"}, {28'd0, dmem_be_o}, {28'd0, e.be});
              chk({tag, "_wdata"}, dmem_wdata_o, e.wdata);
            end
          end
        end
        if (busy == nwait) begin
          dmem_ack_i   = 1'b1;
          dmem_rdata_i = rdata;
        end
        busy++;
      end
      @(posedge clk);
      #1;
      dmem_ack_i = 1'b0;
    end
    if (!done) chk({tag, "_timeout"}, 32'd1, 32'd0);
    chk({tag, "_stall_cycles"}, st, exp_stall);
    chk({tag, "_wb_data"}, reg_write_data_o, exp_wb);
    chk({tag, "_reg_write"}, {31'd0, reg_write_o}, {31'd0, exp_rw});
    chk({tag, "_misalign"}, {31'd0, misalign_o}, {31'd0, exp_mis});
    chk({tag, "_req_idle"}, {31'd0, dmem_req_o}, 32'd0);
    chk({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    rst          = 1'b1;
    valid_i      = 1'b0;
    alu_result_i = 32'd0;
    store_data_i = 32'd0;
    mem_read_i   = 1'b0;
    mem_write_i  = 1'b0;
    funct3_i     = 3'd0;
    reg_write_i  = 1'b0;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
    chk("rst_we", {31'd0, dmem_we_o}, 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    chk("rst_be", {28'd0, dmem_be_o}, 32'd0);
    chk("rst_wdata", dmem_wdata_o, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_mis", {31'd0, misalign_o}, 32'd0);
    chk("rst_rw", {31'd0, reg_write_o}, 32'd0);
    @(posedge clk);
    #1;

    drive(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'd0, 1'b1);
    run("add", 0, 32'd0, 0, 32'h0000_1234, 1'b1, 1'b0);

    drive(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 1'b1);
    exp_q.push_back('{1'b0, 32'h0000_0100, 4'b0000, 32'd0});
    run("lb", 2, 32'h80FF_FF00, 4, 32'hFFFF_FF80, 1'b1, 1'b0);

    drive(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 1'b0);
    exp_q.push_back('{1'b1, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF});
    run("sh", 0, 32'd0, 2, 32'h0000_0202, 1'b0, 1'b0);

    drive(1'b1, 1'b0, 3'b010, 32'h0000_0005, 32'd0, 1'b1);
    run("lw_mis", 0, 32'd0, 0, 32'h0000_0005, 1'b0, 1'b1);

    drive(1'b1, 1'b0, 3'b101, 32'h0000_0010, 32'd0, 1'b1);
    exp_q.push_back('{1'b0, 32'h0000_0010, 4'b0000, 32'd0});
    run("lhu", 0, 32'hDEAD_8001, 2, 32'h0000_8001, 1'b1, 1'b0);

    drive(1'b0, 1'b1, 3'b010, 32'h0000_0014, 32'hCAFE_F00D, 1'b0);
    exp_q.push_back('{1'b1, 32'h0000_0014, 4'b1111, 32'hCAFE_F00D});
    run("sw", 0, 32'd0, 2, 32'h0000_0014, 1'b0, 1'b0);

    drive(1'b1, 1'b0, 3'b001, 32'h0000_0022, 32'd0, 1'b1);
    exp_q.push_back('{1'b0, 32'h0000_0020, 4'b0000, 32'd0});
    run("lh", 1, 32'h9ABC_1234, 3, 32'hFFFF_9ABC, 1'b1, 1'b0);

    drive(1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h1234_5678, 1'b0);
    exp_q.push_back('{1'b1, 32'h0000_0300, 4'b0010, 32'h7878_7878});
    run("sb", 0, 32'd0, 2, 32'h0000_0301, 1'b0, 1'b0);

    drive(1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'd0, 1'b1);
    exp_q.push_back('{1'b0, 32'h0000_0100, 4'b0000, 32'd0});
    run("lbu", 0, 32'h0000_F500, 2, 32'h0000_00F5, 1'b1, 1'b0);

    drive(1'b1, 1'b1, 3'b010, 32'h0000_0030, 32'h5555_5555, 1'b1);
    exp_q.push_back('{1'b0, 32'h0000_0030, 4'b0000, 32'd0});
    run("rd_wr_load", 0, 32'h0BAD_F00D, 2, 32'h0BAD_F00D, 1'b1, 1'b0);

    drive(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstbusy_req", {31'd0, dmem_req_o}, 32'd1);
    chk("rstbusy_addr", dmem_addr_o, 32'h0000_0040);
    chk("rstbusy_stall", {31'd0, stall_o}, 32'd1);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rstbusy_req_drop", {31'd0, dmem_req_o}, 32'd0);
    chk("rstbusy_stall_drop", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    dmem_ack_i = 1'b0;
    @(negedge clk);
    chk("late_ack_req", {31'd0, dmem_req_o}, 32'd0);
    chk("late_ack_stall", {31'd0, stall_o}, 32'd0);
    chk("late_ack_rw", {31'd0, reg_write_o}, 32'd0);
    @(posedge clk);
    #1;

    drive(1'b0, 1'b0, 3'b000, 32'h0000_0777, 32'd0, 1'b1);
    run("post_rst_alu", 0, 32'd0, 0, 32'h0000_0777, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
